// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        PCSRC_SEQ = 2'b00,
        PCSRC_BR  = 2'b01,
        PCSRC_J   = 2'b10,
        PCSRC_JR  = 2'b11
    } pcsrc_e;

    typedef enum logic [1:0] {
        ST_RESET = 2'b00,
        ST_RUN   = 2'b01,
        ST_STALL = 2'b10,
        ST_FLUSH = 2'b11
    } state_e;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcplus4;
        logic        valid;
    } ifid_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: hold freezes everything, flush injects a bubble
// but keeps the previous PC+4 so decode-side consumers see a stable value.
module ifid_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_WORD = NOP
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  hold,
    input  logic  flush,
    input  ifid_t d,
    output ifid_t q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q.instr   <= NOP_WORD;
            q.pcplus4 <= '0;
            q.valid   <= 1'b0;
        end else if (!hold) begin
            if (flush) begin
                q.instr <= NOP_WORD;
                q.valid <= 1'b0;
            end else begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC select, fetch FSM and IF/ID register.
// Optional FETCH_STATS_EN adds saturating fetch/bubble counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = NOP
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] BranchTarget,
    input  logic [31:0] JumpTarget,
    input  logic [31:0] JumpRegTarget,
    output logic [31:0] IM_Address,
    input  logic [31:0] IM_Instruction,
    output logic [31:0] IFID_Instruction,
    output logic [31:0] IFID_PCPlus4,
    output logic        IFID_Valid
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] BubbleCount
`endif
);

    state_e      state;
    logic [31:0] pc, pc_plus4, target;
    logic        hold, redirect;
    ifid_t       ifid_d, ifid_q;

    assign pc_plus4   = pc + 32'd4;
    assign IM_Address = pc;
    assign redirect   = (pcsrc_e'(PCSrc) != PCSRC_SEQ);
    // The edge leaving RESET only arms the pipe: PC and IF/ID stay put.
    assign hold       = (state == ST_RESET) || Stall;

    always_comb begin
        target = pc_plus4;
        case (pcsrc_e'(PCSrc))
            PCSRC_BR: target = BranchTarget;
            PCSRC_J:  target = JumpTarget;
            PCSRC_JR: target = JumpRegTarget;
            default:  target = pc_plus4;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            pc    <= word_align(RESET_PC);
            state <= ST_RESET;
        end else if (state == ST_RESET) begin
            state <= ST_RUN;
        end else if (Stall) begin
            state <= ST_STALL;
        end else if (redirect) begin
            pc    <= word_align(target);
            state <= ST_FLUSH;
        end else begin
            pc    <= pc_plus4;
            state <= ST_RUN;
        end
    end

    assign ifid_d.instr   = IM_Instruction;
    assign ifid_d.pcplus4 = pc_plus4;
    assign ifid_d.valid   = 1'b1;

    ifid_reg #(.NOP_WORD(NOP_WORD)) u_ifid (
        .clk   (Clk),
        .rst   (Rst),
        .hold  (hold),
        .flush (redirect),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign IFID_Instruction = ifid_q.instr;
    assign IFID_PCPlus4     = ifid_q.pcplus4;
    assign IFID_Valid       = ifid_q.valid;

`ifdef FETCH_STATS_EN
    always_ff @(posedge Clk) begin
        if (Rst) begin
            FetchCount  <= '0;
            BubbleCount <= '0;
        end else if (!hold) begin
            if (redirect) begin
                if (BubbleCount != 32'hFFFF_FFFF) BubbleCount <= BubbleCount + 32'd1;
            end else begin
                if (FetchCount != 32'hFFFF_FFFF) FetchCount <= FetchCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; memory returns its own address.
module tb_fetch_stage;

    localparam logic [31:0] NOPW = 32'hDEAD_0013;

    logic        Clk = 1'b0;
    logic        Rst, Stall;
    logic [1:0]  PCSrc;
    logic [31:0] BranchTarget, JumpTarget, JumpRegTarget;
    logic [31:0] IM_Address, IM_Instruction;
    logic [31:0] IFID_Instruction, IFID_PCPlus4;
    logic        IFID_Valid;
`ifdef FETCH_STATS_EN
    logic [31:0] FetchCount, BubbleCount;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 Clk = ~Clk;

    // memory[i] = i*4, i.e. the word at each address equals the address
    assign IM_Instruction = IM_Address;

    fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_WORD(NOPW)) dut (
        .Clk              (Clk),
        .Rst              (Rst),
        .Stall            (Stall),
        .PCSrc            (PCSrc),
        .BranchTarget     (BranchTarget),
        .JumpTarget       (JumpTarget),
        .JumpRegTarget    (JumpRegTarget),
        .IM_Address       (IM_Address),
        .IM_Instruction   (IM_Instruction),
        .IFID_Instruction (IFID_Instruction),
        .IFID_PCPlus4     (IFID_PCPlus4),
        .IFID_Valid       (IFID_Valid)
`ifdef FETCH_STATS_EN
        ,
        .FetchCount       (FetchCount),
        .BubbleCount      (BubbleCount)
`endif
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b1; Stall = 1'b1; PCSrc = 2'b01;
        BranchTarget = 32'h55; JumpTarget = 32'h0; JumpRegTarget = 32'h0;
        step();
        Stall = 1'b0; PCSrc = 2'b00;
        step();
        vectors++;
        if (IM_Address !== 32'h0) begin miscompares++;
            $display("FAIL reset_pc got=%h exp=%h", IM_Address, 32'h0); end
        vectors++;
        if (IFID_Instruction !== NOPW) begin miscompares++;
            $display("FAIL reset_instr got=%h exp=%h", IFID_Instruction, NOPW); end
        vectors++;
        if (IFID_PCPlus4 !== 32'h0 || IFID_Valid !== 1'b0) begin miscompares++;
            $display("FAIL reset_pc4_valid got=%h/%b exp=0/0", IFID_PCPlus4, IFID_Valid); end
`ifdef FETCH_STATS_EN
        vectors++;
        if (FetchCount !== 32'h0 || BubbleCount !== 32'h0) begin miscompares++;
            $display("FAIL reset_stats got=%0d/%0d exp=0/0", FetchCount, BubbleCount); end
`endif
    endtask

    task automatic test_sequential();
        Rst = 1'b0;
        step();  // leave RESET: nothing captured, PC held
        vectors++;
        if (IM_Address !== 32'h0 || IFID_Valid !== 1'b0 || IFID_Instruction !== NOPW) begin
            miscompares++;
            $display("FAIL seq_arm got pc=%h v=%b i=%h exp pc=0 v=0 i=%h",
                     IM_Address, IFID_Valid, IFID_Instruction, NOPW);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if (IM_Address !== 32'(i*4 + 4) || IFID_Instruction !== 32'(i*4) ||
                IFID_PCPlus4 !== 32'(i*4 + 4) || IFID_Valid !== 1'b1) begin
                miscompares++;
                $display("FAIL seq_%0d got pc=%h i=%h p4=%h v=%b exp pc=%h i=%h p4=%h v=1",
                         i, IM_Address, IFID_Instruction, IFID_PCPlus4, IFID_Valid,
                         32'(i*4 + 4), 32'(i*4), 32'(i*4 + 4));
            end
        end
    endtask

    task automatic test_branch();
        // PC is 0x10 here
        PCSrc = 2'b01; BranchTarget = 32'h40;
        step();
        PCSrc = 2'b00;
        vectors++;
        if (IM_Address !== 32'h40 || IFID_Valid !== 1'b0 || IFID_Instruction !== NOPW ||
            IFID_PCPlus4 !== 32'h10) begin
            miscompares++;
            $display("FAIL branch_bubble got pc=%h v=%b i=%h p4=%h exp pc=40 v=0 i=%h p4=10",
                     IM_Address, IFID_Valid, IFID_Instruction, IFID_PCPlus4, NOPW);
        end
        step();
        vectors++;
        if (IM_Address !== 32'h44 || IFID_Instruction !== 32'h40 ||
            IFID_PCPlus4 !== 32'h44 || IFID_Valid !== 1'b1) begin
            miscompares++;
            $display("FAIL branch_fetch got pc=%h i=%h p4=%h v=%b exp pc=44 i=40 p4=44 v=1",
                     IM_Address, IFID_Instruction, IFID_PCPlus4, IFID_Valid);
        end
    endtask

    task automatic test_stall();
        PCSrc = 2'b10; JumpTarget = 32'h1C;
        step();
        PCSrc = 2'b00;
        step();  // PC=0x20, IF/ID holds 0x1C
        vectors++;
        if (IM_Address !== 32'h20 || IFID_Instruction !== 32'h1C) begin miscompares++;
            $display("FAIL stall_setup got pc=%h i=%h exp pc=20 i=1c", IM_Address, IFID_Instruction); end
        Stall = 1'b1; PCSrc = 2'b10; JumpTarget = 32'h80;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (IM_Address !== 32'h20 || IFID_Instruction !== 32'h1C ||
                IFID_PCPlus4 !== 32'h20 || IFID_Valid !== 1'b1) begin
                miscompares++;
                $display("FAIL stall_hold_%0d got pc=%h i=%h p4=%h v=%b exp pc=20 i=1c p4=20 v=1",
                         i, IM_Address, IFID_Instruction, IFID_PCPlus4, IFID_Valid);
            end
        end
        Stall = 1'b0; PCSrc = 2'b00;
        step();
        vectors++;
        if (IM_Address !== 32'h24 || IFID_Instruction !== 32'h20 ||
            IFID_PCPlus4 !== 32'h24 || IFID_Valid !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_resume got pc=%h i=%h p4=%h v=%b exp pc=24 i=20 p4=24 v=1",
                     IM_Address, IFID_Instruction, IFID_PCPlus4, IFID_Valid);
        end
    endtask

    task automatic test_jr();
        PCSrc = 2'b11; JumpRegTarget = 32'h0000_0103;
        step();
        PCSrc = 2'b00;
        vectors++;
        if (IM_Address !== 32'h100 || IFID_Valid !== 1'b0) begin miscompares++;
            $display("FAIL jr_align got pc=%h v=%b exp pc=100 v=0", IM_Address, IFID_Valid); end
        step();
        vectors++;
        if (IFID_Instruction !== 32'h100 || IFID_PCPlus4 !== 32'h104 || IFID_Valid !== 1'b1) begin
            miscompares++;
            $display("FAIL jr_fetch got i=%h p4=%h v=%b exp i=100 p4=104 v=1",
                     IFID_Instruction, IFID_PCPlus4, IFID_Valid);
        end
    endtask

    task automatic test_reset_in_flush();
        PCSrc = 2'b01; BranchTarget = 32'h200;
        step();  // now in FLUSH at 0x200
        Rst = 1'b1; PCSrc = 2'b00;
        step();
        vectors++;
        if (IM_Address !== 32'h0 || IFID_Valid !== 1'b0 || IFID_Instruction !== NOPW ||
            IFID_PCPlus4 !== 32'h0) begin
            miscompares++;
            $display("FAIL flush_reset got pc=%h v=%b i=%h p4=%h exp pc=0 v=0 i=%h p4=0",
                     IM_Address, IFID_Valid, IFID_Instruction, IFID_PCPlus4, NOPW);
        end
`ifdef FETCH_STATS_EN
        vectors++;
        if (FetchCount !== 32'h0 || BubbleCount !== 32'h0) begin miscompares++;
            $display("FAIL flush_reset_stats got=%0d/%0d exp=0/0", FetchCount, BubbleCount); end
`endif
        Rst = 1'b0;
        step();  // RESET -> RUN
    endtask

    task automatic test_wrap();
        PCSrc = 2'b10; JumpTarget = 32'hFFFF_FFFC;
        step();
        PCSrc = 2'b00;
        vectors++;
        if (IM_Address !== 32'hFFFF_FFFC) begin miscompares++;
            $display("FAIL wrap_setup got pc=%h exp pc=fffffffc", IM_Address); end
        step();
        vectors++;
        if (IM_Address !== 32'h0 || IFID_PCPlus4 !== 32'h0 ||
            IFID_Instruction !== 32'hFFFF_FFFC || IFID_Valid !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap got pc=%h p4=%h i=%h v=%b exp pc=0 p4=0 i=fffffffc v=1",
                     IM_Address, IFID_PCPlus4, IFID_Instruction, IFID_Valid);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_stall();
        test_jr();
        test_reset_in_flush();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, PC value loaded on reset.
REQ-002 Parameter NOP_WORD, default 32'h00000000, instruction injected into IF/ID on flush or reset.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Rst  input  1  synchronous, active-high reset.
REQ-005 Stall  input  1  hazard-unit hold; freezes PC and IF/ID.
REQ-006 PCSrc  input  2  next-PC select: 00 PC+4, 01 BranchTarget, 10 JumpTarget, 11 JumpRegTarget.
REQ-007 BranchTarget  input  32  taken-branch target from ID.
REQ-008 JumpTarget  input  32  j/jal target from ID.
REQ-009 JumpRegTarget  input  32  jr target from ID.
REQ-010 IM_Address  output  32  current PC, driven to instruction memory (combinational read).
REQ-011 IM_Instruction  input  32  word returned by instruction memory for IM_Address, same cycle.
REQ-012 IFID_Instruction  output  32  registered instruction to decode.
REQ-013 IFID_PCPlus4  output  32  registered PC+4 of that instruction.
REQ-014 IFID_Valid  output  1  1 when IFID_Instruction is a real fetch, 0 for an injected bubble.

Function
REQ-015 IM_Address SHALL equal the PC register; PC SHALL always be word-aligned, bits [1:0] of every loaded target forced to 00.
REQ-016 PC+4 SHALL be 32-bit modulo add; 32'hFFFFFFFC wraps to 32'h00000000 with no flag.
REQ-017 States: RESET, RUN, STALL, FLUSH (state register, one-hot or binary at implementer's choice).
REQ-018 RESET: entered while Rst=1; on first edge with Rst=0 go RUN; IF/ID holds NOP_WORD, Valid=0.
REQ-019 RUN with Stall=0, PCSrc=00: PC<=PC+4; IF/ID<=IM_Instruction, PC+4, Valid=1; stay RUN.
REQ-020 RUN with Stall=0, PCSrc!=00: PC<=selected target; IF/ID<=NOP_WORD, PCPlus4 unchanged, Valid=0; go FLUSH.
REQ-021 FLUSH: one-cycle bubble state; behaves as RUN for the next edge (new fetch captured normally), returns RUN unless another redirect.
REQ-022 Stall=1 in any non-RESET state: PC and IF/ID hold; go STALL; PCSrc ignored that cycle.
REQ-023 STALL with Stall=0: behave per REQ-019/020 on that edge.
REQ-024 Priority: Rst > Stall > redirect (PCSrc!=00) > sequential.
REQ-025 Redirect latency: target appears on IM_Address exactly one edge after PCSrc sampled; exactly one bubble enters IF/ID per redirect.

Reset
REQ-026 On Rst=1 at an edge: PC<=RESET_PC, IFID_Instruction<=NOP_WORD, IFID_PCPlus4<=0, IFID_Valid<=0, state<=RESET; overrides Stall and PCSrc.
REQ-027 Rst asserted mid-stall or mid-flush SHALL abandon the operation; no partial update survives.

Configuration
REQ-028 Macro FETCH_STATS_EN: when defined, adds outputs FetchCount[31:0] (increments per Valid=1 capture) and BubbleCount[31:0] (increments per flush bubble), both cleared by Rst, saturating at 32'hFFFFFFFF.
REQ-029 Without FETCH_STATS_EN the ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-030 Shared package holds PCSrc encodings (PCSRC_SEQ, PCSRC_BR, PCSRC_J, PCSRC_JR), state encodings, and NOP constant.
REQ-031 One sub-module, ifid_reg, holds the IF/ID register with hold and flush controls; PC logic and FSM stay in fetch_stage.

Verification
REQ-032 Rst 2 cycles, release, PCSrc=00, memory[i]=i*4 -> IM_Address 0,4,8,...; IFID_Instruction 0,4,8 one cycle later, Valid=1.
REQ-033 At PC=0x10 assert PCSrc=01, BranchTarget=0x40 one cycle -> next IM_Address=0x40, IFID Valid=0 one cycle, then instruction 0x40 with PCPlus4=0x44.
REQ-034 Stall=1 for 3 cycles at PC=0x20 with PCSrc=10 -> PC stays 0x20, IF/ID unchanged, no bubble; after release sequential fetch resumes at 0x24.
REQ-035 PCSrc=11, JumpRegTarget=0x00000103 -> IM_Address=0x00000100.
REQ-036 Rst asserted during FLUSH -> PC=RESET_PC, Valid=0 next edge; with FETCH_STATS_EN both counters read 0.
REQ-037 PC forced to 0xFFFFFFFC, PCSrc=00 -> next IM_Address 0x00000000, IFID_PCPlus4=0x00000000.
